scff_bank: RTL and testbench

Parametrised successor to the single-bit scan cell: a WIDTH-bit scan/configuration register bank.
- Serial shift chain (SI→SO) feeds a separate shadow output register Q.
- A frame counter and FSM track complete frames; Q changes only on a committed update.
- Parallel capture supports readback.
- Sits between the configuration/scan controller and the fabric cells it configures.

---
 rtl/scff_pkg.sv | 19 +
 rtl/scff_frame_cnt.sv | 72 +++++++
 rtl/scff_bank.sv | 80 ++++++++
 tb/tb_scff_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/scff_pkg.sv
// Shared types and helpers for the scan/configuration register bank.
package scff_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFTING = 2'd1,
        FULL     = 2'd2
    } scff_state_e;

    // Counter must represent 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_WIDTH = 16;

    typedef logic [cnt_width(DEFAULT_WIDTH)-1:0] scff_cnt_t;

endpackage

// File: rtl/scff_frame_cnt.sv
// Frame-tracking FSM with a saturating shift counter and overflow flag.
module scff_frame_cnt
    import scff_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int CW   = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          R,
    input  logic          se,
    input  logic          ce,
    input  logic          ue,
    output scff_state_e   state,
    output logic [CW-1:0] cnt,
    output logic          frame_done,
    output logic          ovf
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    scff_state_e   state_n;
    logic [CW-1:0] cnt_n;
    logic          frame_done_n;
    logic          ovf_n;

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            frame_done <= frame_done_n;
            ovf        <= ovf_n;
        end
    end

    // Priority CE > UE > SE; in IDLE cnt is 0 so IDLE and SHIFTING share the increment.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        frame_done_n = 1'b0;
        ovf_n        = ovf;
        if (ce) begin
            state_n      = FULL;
            cnt_n        = CNT_MAX;
            ovf_n        = 1'b0;
            frame_done_n = 1'b1;
        end else if (ue) begin
            if (state == FULL) begin
                state_n = IDLE;
                cnt_n   = '0;
                ovf_n   = 1'b0;
            end
        end else if (se) begin
            if (state == FULL) begin
                ovf_n = 1'b1;
            end else begin
                cnt_n = cnt + CW'(1);
                if (cnt_n == CNT_MAX) begin
                    state_n      = FULL;
                    frame_done_n = 1'b1;
                end else begin
                    state_n = SHIFTING;
                end
            end
        end
    end

endmodule

// File: rtl/scff_bank.sv
// WIDTH-bit scan chain with a shadow output register committed only on a full-frame update.
module scff_bank
    import scff_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter logic             SO_INVERT = 1'b0,
    localparam int              CW        = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             R,
    input  logic             SI,
    input  logic             SE,
    input  logic             CE,
    input  logic             UE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             frame_done,
    output logic             upd_ack,
    output logic             upd_err,
    output logic             ovf,
    output logic [CW-1:0]    cnt
);

    scff_state_e      state;
    logic [WIDTH-1:0] chain;
    logic [WIDTH-1:0] chain_sh;
    logic             do_shift;
    logic             do_update;
    logic             do_err;

    scff_frame_cnt #(.WIDTH(WIDTH)) u_frame_cnt (
        .clk        (clk),
        .R          (R),
        .se         (SE),
        .ce         (CE),
        .ue         (UE),
        .state      (state),
        .cnt        (cnt),
        .frame_done (frame_done),
        .ovf        (ovf)
    );

    generate
        if (WIDTH == 1) begin : g_one
            assign chain_sh = SI;
        end else begin : g_many
            assign chain_sh = {chain[WIDTH-2:0], SI};
        end
    endgenerate

    assign do_update = !CE && UE && (state == FULL);
    assign do_err    = !CE && UE && (state != FULL);
    assign do_shift  = !CE && !UE && SE;

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            chain   <= '0;
            Q       <= INIT;
            upd_ack <= 1'b0;
            upd_err <= 1'b0;
        end else begin
            upd_ack <= do_update;
            upd_err <= do_err;
            if (CE) begin
                chain <= D;
            end else if (do_shift) begin
                chain <= chain_sh;
            end
            // Q takes the chain as it stood before this edge.
            if (do_update) begin
                Q <= chain;
            end
        end
    end

    assign SO = chain[WIDTH-1] ^ SO_INVERT;

endmodule

// File: tb/tb_scff_bank.sv
// Directed self-checking bench for scff_bank (WIDTH=8 bank and WIDTH=1 inverted-SO bank).
module tb_scff_bank;

    logic       clk = 1'b0;
    logic       r;
    logic       si, se, ce, ue;
    logic [7:0] d;
    logic [7:0] q;
    logic       so, frame_done, upd_ack, upd_err, ovf;
    logic [3:0] cnt;

    logic       si1, se1, ce1, ue1;
    logic [0:0] d1;
    logic [0:0] q1;
    logic       so1, frame_done1, upd_ack1, upd_err1, ovf1;
    logic [0:0] cnt1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pat;
    logic [4:0] pat5;
    logic [2:0] pat3;

    always #5 clk = ~clk;

    scff_bank #(.WIDTH(8), .INIT(8'hA5), .SO_INVERT(1'b0)) dut (
        .clk(clk), .R(r), .SI(si), .SE(se), .CE(ce), .UE(ue), .D(d),
        .Q(q), .SO(so), .frame_done(frame_done), .upd_ack(upd_ack),
        .upd_err(upd_err), .ovf(ovf), .cnt(cnt)
    );

    scff_bank #(.WIDTH(1), .INIT(1'b0), .SO_INVERT(1'b1)) dut1 (
        .clk(clk), .R(r), .SI(si1), .SE(se1), .CE(ce1), .UE(ue1), .D(d1),
        .Q(q1), .SO(so1), .frame_done(frame_done1), .upd_ack(upd_ack1),
        .upd_err(upd_err1), .ovf(ovf1), .cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        r = 1'b0; si = 0; se = 0; ce = 0; ue = 0; d = '0;
        si1 = 0; se1 = 0; ce1 = 0; ue1 = 0; d1 = '0;
        repeat (2) tick;
        chk("rst_q", q, 8'hA5);
        chk("rst_cnt", cnt, 0);
        r = 1'b1;

        // Full frame 8'hCA, MSB first, then commit
        pat = 8'hCA;
        for (int i = 7; i >= 0; i--) begin
            si = pat[i]; se = 1;
            tick;
            chk("t2_cnt", cnt, 8 - i);
            chk("t2_fd", frame_done, (i == 0));
        end
        se = 0; ue = 1;
        tick;
        chk("t2_q", q, 8'hCA);
        chk("t2_ack", upd_ack, 1);
        chk("t2_cnt0", cnt, 0);
        chk("t2_fd_off", frame_done, 0);
        ue = 0;
        tick;
        chk("t2_ack_off", upd_ack, 0);
        chk("t2_q_hold", q, 8'hCA);

        // Partial frame + UE -> error, then complete frame
        pat3 = 3'b110;
        for (int i = 2; i >= 0; i--) begin
            si = pat3[i]; se = 1;
            tick;
        end
        se = 0; ue = 1;
        tick;
        chk("t3_err", upd_err, 1);
        chk("t3_q", q, 8'hCA);
        chk("t3_cnt", cnt, 3);
        chk("t3_ack", upd_ack, 0);
        ue = 0;
        tick;
        chk("t3_err_off", upd_err, 0);
        chk("t3_cnt_hold", cnt, 3);
        pat5 = 5'b01010;
        for (int i = 4; i >= 0; i--) begin
            si = pat5[i]; se = 1;
            tick;
            chk("t3_cnt_run", cnt, 8 - i);
            chk("t3_fd", frame_done, (i == 0));
        end

        // Overflow: two extra shifts of 1
        si = 1; se = 1;
        tick;
        chk("t4_ovf1", ovf, 1);
        chk("t4_cnt1", cnt, 8);
        chk("t4_fd", frame_done, 0);
        tick;
        chk("t4_ovf2", ovf, 1);
        chk("t4_cnt2", cnt, 8);
        se = 0; ue = 1;
        tick;
        chk("t4_q", q, 8'h2B);
        chk("t4_ovf_clr", ovf, 0);
        chk("t4_ack", upd_ack, 1);
        chk("t4_cnt0", cnt, 0);
        ue = 0;

        // CE wins over UE and SE
        d = 8'h3C; ce = 1; se = 1; ue = 1; si = 1;
        tick;
        chk("t5_fd", frame_done, 1);
        chk("t5_cnt", cnt, 8);
        chk("t5_ack", upd_ack, 0);
        chk("t5_err", upd_err, 0);
        chk("t5_q", q, 8'h2B);
        chk("t5_ovf", ovf, 0);
        ce = 0; ue = 0; se = 1; si = 1;
        pat = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            chk("t5_so", so, pat[i]);
            tick;
        end
        se = 0;
        chk("t5_ovf_end", ovf, 1);
        chk("t5_so_ones", so, 1);

        // Asynchronous reset between edges
        #2;
        r = 1'b0;
        #1;
        chk("t1_q", q, 8'hA5);
        chk("t1_cnt", cnt, 0);
        chk("t1_so", so, 0);
        chk("t1_fd", frame_done, 0);
        chk("t1_ack", upd_ack, 0);
        chk("t1_err", upd_err, 0);
        chk("t1_ovf", ovf, 0);
        chk("t1_q1", q1, 0);
        chk("t1_so1", so1, 1);
        tick;
        r = 1'b1;
        ue = 1;
        tick;
        chk("t1_idle_err", upd_err, 1);
        chk("t1_idle_q", q, 8'hA5);
        ue = 0;

        // WIDTH=1 with inverted SO
        si1 = 1; se1 = 1;
        tick;
        chk("t6_fd", frame_done1, 1);
        chk("t6_so", so1, 0);
        chk("t6_cnt", cnt1, 1);
        se1 = 0; ue1 = 1;
        tick;
        chk("t6_q", q1, 1);
        chk("t6_ack", upd_ack1, 1);
        chk("t6_fd_off", frame_done1, 0);
        ue1 = 0;
        tick;
        chk("t6_ack_off", upd_ack1, 0);
        chk("t6_q_hold", q1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
